// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, keeps one request outstanding to instruction
// memory, and hands words to decode through an output register plus a 1-entry skid.
module instr_fetch #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = WIDTH'(32'h80020000)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic [WIDTH-1:0] if_pc_plus4
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_instr_q, if_instr_d;
    logic [WIDTH-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [WIDTH-1:0] skid_instr_q, skid_instr_d;

    logic             ack_ok;
    logic             consume;
    logic [WIDTH-1:0] redir_pc;

    // The request is gated by reset so a stray ack during reset can never be accepted.
    assign imem_req  = !reset && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign imem_addr = pc_q;
    assign ack_ok    = imem_ack && imem_req;
    assign consume   = if_valid_q && !stall;
    assign redir_pc  = redirect_pc & ~WIDTH'(3);

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;

        if (redirect_valid) begin
            if_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
            // An unanswered request cannot be withdrawn, so its response is drained first.
            if ((state_q == S_FETCH) && !ack_ok) begin
                pend_pc_d = redir_pc;
                state_d   = S_DRAIN;
            end else if ((state_q == S_DRAIN) && !ack_ok) begin
                pend_pc_d = redir_pc;
            end else begin
                pc_d    = redir_pc;
                state_d = S_FETCH;
            end
        end else begin
            if (consume) begin
                if_valid_d = 1'b0;
            end
            case (state_q)
                S_FETCH: begin
                    if (ack_ok) begin
                        pc_d = pc_q + WIDTH'(4);
                        if (!if_valid_q || consume) begin
                            if_valid_d    = 1'b1;
                            if_pc_d       = pc_q;
                            if_instr_d    = imem_rdata;
                            if_pc_plus4_d = pc_q + WIDTH'(4);
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata;
                            state_d      = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (consume) begin
                        if_valid_d    = 1'b1;
                        if_pc_d       = skid_pc_q;
                        if_instr_d    = skid_instr_q;
                        if_pc_plus4_d = skid_pc_q + WIDTH'(4);
                        skid_valid_d  = 1'b0;
                        state_d       = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ack_ok) begin
                        pc_d    = pend_pc_q;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
            if_pc_plus4_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

endmodule
